wb_master_engine: RTL and testbench

- Synthesizable, parametrised Wishbone B3 classic-cycle master for the ethmac environment.
- Accepts single or incrementing-burst read/write commands on a valid/ready command port.
- Streams write data in and read data out over valid/ready ports.
- Holds CYC across all beats of a burst, terminates on ERR, and aborts on an ack timeout. It reports one status pulse per command.

---
 rtl/wb_master_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_wb_master_engine.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_engine.sv
// Wishbone B3 classic-cycle master: single/incrementing-burst reads and writes.
// Optional retry support (wb_rty_i) is enabled by defining WB_MS_RETRY_EN.
module wb_master_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int LEN_WIDTH      = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic                  done_valid,
    output logic                  done_err,
    output logic                  done_timeout,
    output logic [ADDR_WIDTH-3:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
`ifdef WB_MS_RETRY_EN
    input  logic                  wb_rty_i,
`endif
    input  logic                  wb_err_i
);

    localparam int AW   = ADDR_WIDTH - 2;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, BUS, RESP, DONE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  err_q, err_d, tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_last_q, rsp_last_d, rsp_err_q, rsp_err_d;
    logic                  cmd_ready_q, cmd_ready_d, wdata_ready_q, wdata_ready_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, rsp_valid_q, rsp_valid_d;
    logic                  done_valid_q, done_valid_d, done_err_q, done_err_d;
    logic                  done_tmo_q, done_tmo_d;
    logic                  beat_ok, beat_err, beat_tmo;
`ifdef WB_MS_RETRY_EN
    logic                  rty_gap_q, rty_gap_d;
    logic [2:0]            rty_cnt_q, rty_cnt_d;
`endif

    logic [1:0] unused_addr_lsb;
    assign unused_addr_lsb = cmd_addr[1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            we_q          <= 1'b0;
            cnt_q         <= '0;
            to_q          <= '0;
            err_q         <= 1'b0;
            tmo_q         <= 1'b0;
            rsp_data_q    <= '0;
            rsp_last_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            done_valid_q  <= 1'b0;
            done_err_q    <= 1'b0;
            done_tmo_q    <= 1'b0;
`ifdef WB_MS_RETRY_EN
            rty_gap_q     <= 1'b0;
            rty_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            dat_q         <= dat_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            to_q          <= to_d;
            err_q         <= err_d;
            tmo_q         <= tmo_d;
            rsp_data_q    <= rsp_data_d;
            rsp_last_q    <= rsp_last_d;
            rsp_err_q     <= rsp_err_d;
            cmd_ready_q   <= cmd_ready_d;
            wdata_ready_q <= wdata_ready_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            rsp_valid_q   <= rsp_valid_d;
            done_valid_q  <= done_valid_d;
            done_err_q    <= done_err_d;
            done_tmo_q    <= done_tmo_d;
`ifdef WB_MS_RETRY_EN
            rty_gap_q     <= rty_gap_d;
            rty_cnt_q     <= rty_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        rsp_data_d = rsp_data_q;
        rsp_last_d = rsp_last_q;
        rsp_err_d  = rsp_err_q;
        beat_ok    = 1'b0;
        beat_err   = 1'b0;
        beat_tmo   = 1'b0;
`ifdef WB_MS_RETRY_EN
        rty_gap_d  = rty_gap_q;
        rty_cnt_d  = rty_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_addr[ADDR_WIDTH-1:2];
                    cnt_d   = cmd_len;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    to_d    = '0;
                    state_d = cmd_we ? FETCH : BUS;
`ifdef WB_MS_RETRY_EN
                    rty_cnt_d = '0;
`endif
                end
            end
            FETCH: begin
                if (wdata_valid && wdata_ready_q) begin
                    dat_d   = wdata;
                    to_d    = '0;
                    state_d = BUS;
`ifdef WB_MS_RETRY_EN
                    rty_cnt_d = '0;
`endif
                end
            end
            BUS: begin
                // Response priority: ERR, then RTY (fifth in a row escalates), then ACK, then timeout.
`ifdef WB_MS_RETRY_EN
                if (rty_gap_q) begin
                    rty_gap_d = 1'b0;
                    to_d      = '0;
                end else
`endif
                if (wb_err_i) begin
                    beat_err = 1'b1;
                end
`ifdef WB_MS_RETRY_EN
                else if (wb_rty_i) begin
                    if (rty_cnt_q == 3'd4) begin
                        beat_err = 1'b1;
                    end else begin
                        rty_cnt_d = rty_cnt_q + 3'd1;
                        rty_gap_d = 1'b1;
                    end
                end
`endif
                else if (wb_ack_i) begin
                    beat_ok = 1'b1;
                end else if (to_q == TO_LIMIT) begin
                    beat_tmo = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end

                if (beat_ok) begin
                    adr_d = adr_q + AW'(1);
                    if (cnt_q != '0) cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (we_q) begin
                        state_d = (cnt_q == '0) ? DONE : FETCH;
                    end else begin
                        rsp_data_d = wb_dat_i;
                        rsp_last_d = (cnt_q == '0);
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end
                end else if (beat_err || beat_tmo) begin
                    err_d = beat_err;
                    tmo_d = beat_tmo;
                    if (we_q) begin
                        state_d = DONE;
                    end else begin
                        rsp_data_d = '0;
                        rsp_last_d = 1'b1;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready && rsp_valid_q) begin
                    to_d    = '0;
                    state_d = rsp_last_q ? DONE : BUS;
`ifdef WB_MS_RETRY_EN
                    rty_cnt_d = '0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, decoded from the state being entered.
    always_comb begin
        cmd_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == FETCH);
        cyc_d         = (state_d == FETCH || state_d == BUS || state_d == RESP) && !tmo_d;
        stb_d         = (state_d == BUS);
`ifdef WB_MS_RETRY_EN
        stb_d         = stb_d && !rty_gap_d;
`endif
        rsp_valid_d   = (state_d == RESP);
        done_valid_d  = (state_d == DONE);
        done_err_d    = (state_d == DONE) && err_d;
        done_tmo_d    = (state_d == DONE) && tmo_d;
    end

    assign cmd_ready    = cmd_ready_q;
    assign wdata_ready  = wdata_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_last     = rsp_last_q;
    assign rsp_err      = rsp_err_q;
    assign done_valid   = done_valid_q;
    assign done_err     = done_err_q;
    assign done_timeout = done_tmo_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine with a small Wishbone slave and stream models.
// Retry scenarios are included when WB_MS_RETRY_EN is defined.
module tb_wb_master_engine;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 5;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [3:0]    cmd_sel = '0;
    logic          wdata_valid = 1'b1, wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_last, rsp_err;
    logic [DW-1:0] rsp_data;
    logic          done_valid, done_err, done_timeout;
    logic [AW-3:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o, wb_dat_i = '0;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i = 1'b0, wb_err_i = 1'b0;
`ifdef WB_MS_RETRY_EN
    logic          wb_rty_i = 1'b0;
    int            rtyLeft = 0;
`endif

    int vectors = 0, miscompares = 0;

    // Slave / stream model knobs and logs.
    int  stbAge = 0, beatIdx = 0, ackWait = 0, errOnBeat = 0;
    bit  noAck = 0, rspToggle = 0, wHs = 0, cycSeen = 0;
    logic [DW-1:0] rdTab [8];
    logic [DW-1:0] wrTab [8];
    int  issueCount = 0, stbCycles = 0, rspCount = 0, doneCount = 0, wIdx = 0, cycGap = 0;
    logic [AW-3:0] issueAdr [16];
    logic [DW-1:0] issueDat [16];
    logic          issueWe [16];
    logic [3:0]    issueSel [16];
    logic [DW-1:0] rspData [8];
    logic          rspLast [8], rspErr [8], rspCyc [8];
    logic          lastDoneErr = 1'b0, lastDoneTmo = 1'b0;

    wb_master_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(4), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_err(rsp_err),
        .done_valid(done_valid), .done_err(done_err), .done_timeout(done_timeout),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
`ifdef WB_MS_RETRY_EN
        .wb_rty_i(wb_rty_i),
`endif
        .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    // Slave, write-data source, response sink and loggers, all driven 1ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wHs) wIdx++;
        wdata    = wrTab[wIdx % 8];
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
`ifdef WB_MS_RETRY_EN
        wb_rty_i = 1'b0;
`endif
        if (wb_stb_o && wb_cyc_o) begin
            stbAge++;
            stbCycles++;
            if (stbAge == 1) begin
                if (issueCount < 16) begin
                    issueAdr[issueCount] = wb_adr_o;
                    issueDat[issueCount] = wb_dat_o;
                    issueWe[issueCount]  = wb_we_o;
                    issueSel[issueCount] = wb_sel_o;
                end
                issueCount++;
            end
            if (!noAck && stbAge >= ackWait + 1) begin
`ifdef WB_MS_RETRY_EN
                if (rtyLeft > 0) begin
                    wb_rty_i = 1'b1;
                    rtyLeft--;
                end else
`endif
                if (beatIdx + 1 == errOnBeat) begin
                    wb_err_i = 1'b1;
                    beatIdx++;
                end else begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = rdTab[beatIdx % 8];
                    beatIdx++;
                end
            end
        end else begin
            stbAge = 0;
        end
        if (rspToggle) rsp_ready = ~rsp_ready;
        if (rsp_valid && rsp_ready) begin
            if (rspCount < 8) begin
                rspData[rspCount] = rsp_data;
                rspLast[rspCount] = rsp_last;
                rspErr[rspCount]  = rsp_err;
                rspCyc[rspCount]  = wb_cyc_o;
            end
            rspCount++;
        end
        if (done_valid) begin
            doneCount++;
            lastDoneErr = done_err;
            lastDoneTmo = done_timeout;
            cycSeen = 0;
        end else if (wb_cyc_o) begin
            cycSeen = 1;
        end else if (cycSeen) begin
            cycGap++;
        end
        wHs = wdata_valid && wdata_ready;
    end

    task automatic clearLogs();
        @(negedge clk);
        issueCount = 0; stbCycles = 0; rspCount = 0; doneCount = 0;
        wIdx = 0; wHs = 0; beatIdx = 0; cycGap = 0; cycSeen = 0;
        ackWait = 0; errOnBeat = 0; noAck = 0; rspToggle = 0; rsp_ready = 1'b1;
        lastDoneErr = 1'b0; lastDoneTmo = 1'b0;
    endtask

    task automatic issueCmd(input logic we, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [3:0] sel);
        int t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            vectors++; miscompares++;
            $display("[TB] FAIL cmd_accept: cmd_ready stayed %b, required 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int t;
        t = 0;
        while (doneCount == 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (doneCount == 0) begin
            miscompares++;
            $display("[TB] FAIL done_seen: no done pulse within %0d cycles, required 1", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cmd_ready, wb_cyc_o, wb_stb_o, rsp_valid, done_valid, wdata_ready, wb_we_o} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got %b required 0000000",
                     {cmd_ready, wb_cyc_o, wb_stb_o, rsp_valid, done_valid, wdata_ready, wb_we_o});
        end
        vectors++;
        if (wb_adr_o !== 10'h000 || wb_dat_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_bus: adr %h dat %h required 0", wb_adr_o, wb_dat_o);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_single_write();
        clearLogs();
        ackWait = 1;
        wrTab[0] = 32'hDEADBEEF;
        wdata = wrTab[0];
        issueCmd(1'b1, 12'h040, 5'd0, 4'hF);
        waitDone(60);
        vectors++;
        if (issueCount !== 1 || stbCycles !== 2) begin
            miscompares++;
            $display("[TB] FAIL wr_beats: issues %0d stb %0d required 1 and 2", issueCount, stbCycles);
        end
        vectors++;
        if (issueAdr[0] !== 10'h010 || issueDat[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL wr_bus: adr %h dat %h required 010 deadbeef", issueAdr[0], issueDat[0]);
        end
        vectors++;
        if (issueWe[0] !== 1'b1 || issueSel[0] !== 4'hF) begin
            miscompares++;
            $display("[TB] FAIL wr_we_sel: we %b sel %h required 1 f", issueWe[0], issueSel[0]);
        end
        vectors++;
        if (doneCount !== 1 || lastDoneErr !== 1'b0 || lastDoneTmo !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_done: count %0d err %b tmo %b required 1 0 0",
                     doneCount, lastDoneErr, lastDoneTmo);
        end
    endtask

    task automatic test_burst_read();
        logic [DW-1:0] exp [4];
        clearLogs();
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
        for (int i = 0; i < 4; i++) rdTab[i] = exp[i];
        rspToggle = 1;
        issueCmd(1'b0, 12'h100, 5'd3, 4'hF);
        waitDone(100);
        vectors++;
        if (issueCount !== 4 || rspCount !== 4) begin
            miscompares++;
            $display("[TB] FAIL rd_counts: issues %0d rsps %0d required 4 4", issueCount, rspCount);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (issueAdr[i] !== 10'(10'h040 + i) || issueWe[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rd_adr[%0d]: got %h we %b required %h 0", i, issueAdr[i],
                         issueWe[i], 10'(10'h040 + i));
            end
            vectors++;
            if (rspData[i] !== exp[i] || rspLast[i] !== (i == 3) || rspErr[i] !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rd_rsp[%0d]: data %h last %b err %b required %h %b 0", i,
                         rspData[i], rspLast[i], rspErr[i], exp[i], (i == 3));
            end
        end
        vectors++;
        if (cycGap !== 0 || lastDoneErr !== 1'b0 || lastDoneTmo !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_cyc: cyc low %0d cycles, err %b tmo %b required 0 0 0",
                     cycGap, lastDoneErr, lastDoneTmo);
        end
    endtask

    task automatic test_err_burst();
        clearLogs();
        for (int i = 0; i < 8; i++) wrTab[i] = 32'hA000_0000 + 32'(i);
        wdata = wrTab[0];
        errOnBeat = 3;
        issueCmd(1'b1, 12'h200, 5'd7, 4'h3);
        waitDone(100);
        vectors++;
        if (issueCount !== 3 || wIdx !== 3) begin
            miscompares++;
            $display("[TB] FAIL err_beats: issues %0d wdata %0d required 3 3", issueCount, wIdx);
        end
        vectors++;
        if (issueDat[2] !== 32'hA000_0002 || issueAdr[2] !== 10'h082) begin
            miscompares++;
            $display("[TB] FAIL err_beat3: dat %h adr %h required a0000002 082", issueDat[2], issueAdr[2]);
        end
        vectors++;
        if (doneCount !== 1 || lastDoneErr !== 1'b1 || lastDoneTmo !== 1'b0 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_done: count %0d err %b tmo %b cyc %b required 1 1 0 0",
                     doneCount, lastDoneErr, lastDoneTmo, wb_cyc_o);
        end
    endtask

    task automatic test_timeout();
        clearLogs();
        noAck = 1;
        issueCmd(1'b0, 12'h300, 5'd2, 4'hF);
        waitDone(100);
        vectors++;
        if (stbCycles !== TO || issueCount !== 1) begin
            miscompares++;
            $display("[TB] FAIL tmo_stb: stb %0d issues %0d required %0d 1", stbCycles, issueCount, TO);
        end
        vectors++;
        if (rspCount !== 1 || rspErr[0] !== 1'b1 || rspLast[0] !== 1'b1 || rspData[0] !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL tmo_rsp: count %0d err %b last %b data %h required 1 1 1 0",
                     rspCount, rspErr[0], rspLast[0], rspData[0]);
        end
        vectors++;
        if (rspCyc[0] !== 1'b0 || lastDoneTmo !== 1'b1 || lastDoneErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tmo_done: cyc %b tmo %b err %b required 0 1 0",
                     rspCyc[0], lastDoneTmo, lastDoneErr);
        end
        noAck = 0;
    endtask

    task automatic test_wrap_reset();
        int t;
        clearLogs();
        wrTab[0] = 32'h0000_1111; wrTab[1] = 32'h0000_2222;
        wdata = wrTab[0];
        issueCmd(1'b1, 12'hFFC, 5'd1, 4'hF);
        waitDone(60);
        vectors++;
        if (issueAdr[0] !== 10'h3FF || issueAdr[1] !== 10'h000) begin
            miscompares++;
            $display("[TB] FAIL wrap_adr: got %h %h required 3ff 000", issueAdr[0], issueAdr[1]);
        end
        vectors++;
        if (issueDat[1] !== 32'h0000_2222 || lastDoneErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_dat: got %h err %b required 00002222 0", issueDat[1], lastDoneErr);
        end

        clearLogs();
        noAck = 1;
        issueCmd(1'b0, 12'h020, 5'd0, 4'hF);
        t = 0;
        while (!wb_stb_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid, done_valid} !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_mid: cyc/stb/rsp/done %b required 0000",
                     {wb_cyc_o, wb_stb_o, rsp_valid, done_valid});
        end
        @(negedge clk);
        reset = 1'b0;
        noAck = 0;
        repeat (20) @(negedge clk);
        vectors++;
        if (doneCount !== 0 || wb_cyc_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_nodone: done %0d cyc %b required 0 0", doneCount, wb_cyc_o);
        end
    endtask

`ifdef WB_MS_RETRY_EN
    task automatic test_retry();
        clearLogs();
        wrTab[0] = 32'hCAFE_0001;
        wdata = wrTab[0];
        rtyLeft = 2;
        issueCmd(1'b1, 12'h040, 5'd0, 4'hF);
        waitDone(80);
        vectors++;
        if (issueCount !== 3 || issueAdr[2] !== 10'h010 || issueDat[2] !== 32'hCAFE_0001) begin
            miscompares++;
            $display("[TB] FAIL rty2_beats: issues %0d adr %h dat %h required 3 010 cafe0001",
                     issueCount, issueAdr[2], issueDat[2]);
        end
        vectors++;
        if (lastDoneErr !== 1'b0 || doneCount !== 1) begin
            miscompares++;
            $display("[TB] FAIL rty2_done: err %b count %0d required 0 1", lastDoneErr, doneCount);
        end

        clearLogs();
        rtyLeft = 5;
        issueCmd(1'b1, 12'h040, 5'd0, 4'hF);
        waitDone(80);
        vectors++;
        if (issueCount !== 5 || lastDoneErr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rty5: issues %0d err %b required 5 1", issueCount, lastDoneErr);
        end
        rtyLeft = 0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 8; i++) begin
            rdTab[i] = '0;
            wrTab[i] = '0;
        end
        test_reset();
        test_single_write();
        test_burst_read();
        test_err_burst();
        test_timeout();
        test_wrap_reset();
`ifdef WB_MS_RETRY_EN
        test_retry();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
